// File: rtl/vm3_mux_pkg.sv
// Shared constants and frame helpers for the VM3 3-wire mux link serializer.
package vm3_mux_pkg;
  localparam int         NSLOT    = 4;
  localparam int         SLOT_W   = $clog2(NSLOT);
  localparam logic [1:0] STB_SLOT = 2'd3;

  localparam int F_DCLO   = 7;
  localparam int F_ACLO   = 6;
  localparam int F_HALT   = 5;
  localparam int F_EVNT   = 4;
  localparam int F_IRQ_HI = 3;
  localparam int F_IRQ_LO = 0;

  localparam logic [1:0] MX_IDLE = 2'b11;

  typedef logic [7:0] frame_t;

  // Link levels are inverted: 1 on the wire means deasserted.
  function automatic frame_t packFrame(input logic dclo, input logic aclo,
                                       input logic halt, input logic evnt,
                                       input logic [3:0] irq);
    frame_t f;
    f[F_DCLO]              = ~dclo;
    f[F_ACLO]              = ~aclo;
    f[F_HALT]              = ~halt;
    f[F_EVNT]              = ~evnt;
    f[F_IRQ_HI:F_IRQ_LO]   = ~irq;
    return f;
  endfunction

  function automatic logic [1:0] slotBits(input frame_t f, input logic [SLOT_W-1:0] s);
    case (s)
      2'd0:    return f[7:6];
      2'd1:    return f[5:4];
      2'd2:    return f[3:2];
      default: return f[1:0];
    endcase
  endfunction
endpackage

// File: rtl/vm3_mux_clkdiv.sv
// MCLK generator: DIV CLK cycles per half-period, plus the update strobes
// that sit one CLK after each MCLK edge.
module vm3_mux_clkdiv #(
  parameter int DIV = 2
) (
  input  logic CLK,
  input  logic nRST,
  output logic MCLK,
  output logic upd_lo,
  output logic upd_hi,
  output logic rise
);
  generate
    if (DIV < 2) begin : g_badDiv
      $error("vm3_mux_clkdiv: DIV must be >= 2");
    end
  endgenerate

  localparam int HW = $clog2(DIV);

  logic [HW-1:0] hc;
  logic          ph;
  logic          last;

  assign last = (hc == HW'(DIV - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hc <= '0;
      ph <= 1'b0;
    end else if (last) begin
      hc <= '0;
      ph <= ~ph;
    end else begin
      hc <= hc + 1'b1;
    end
  end

  assign MCLK   = ph;
  assign upd_lo = (hc == '0) && !ph;
  assign upd_hi = (hc == '0) &&  ph;
  assign rise   = last && !ph;
endmodule

// File: rtl/vm3_mux_tx.sv
// Serializes DCLO/ACLO/HALT/EVNT/IRQ into 4-slot frames on MXOUT and
// time-shares the high MCLK phase for DMR/SACK.
module vm3_mux_tx
  import vm3_mux_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       DCLO,
  input  logic       ACLO,
  input  logic       HALT,
  input  logic       EVNT,
  input  logic [3:0] IRQ,
  input  logic       DMR,
  input  logic       SACK,
  output logic       MCLK,
  output logic [1:0] MXOUT,
  output logic       MXSTB,
  output logic       FRAME,
  output logic       LINKUP
);
  logic              upd_lo, upd_hi, rise;
  logic [SLOT_W-1:0] slot;
  frame_t            snap;
  frame_t            frm;

  vm3_mux_clkdiv #(.DIV(DIV)) u_clkdiv (
    .CLK    (CLK),
    .nRST   (nRST),
    .MCLK   (MCLK),
    .upd_lo (upd_lo),
    .upd_hi (upd_hi),
    .rise   (rise)
  );

  // Slot 0 drives straight from the fresh snapshot so the frame stays coherent.
  assign frm = (slot == '0) ? packFrame(DCLO, ACLO, HALT, EVNT, IRQ) : snap;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      slot   <= '0;
      snap   <= 8'hFF;
      MXOUT  <= MX_IDLE;
      MXSTB  <= 1'b0;
      FRAME  <= 1'b0;
      LINKUP <= 1'b0;
    end else begin
      FRAME <= 1'b0;
      if (upd_lo) begin
        if (slot == '0) snap <= frm;
        MXOUT <= slotBits(frm, slot);
        MXSTB <= (slot == STB_SLOT);
        FRAME <= (slot == STB_SLOT);
        slot  <= slot + 1'b1;
      end else if (upd_hi) begin
        MXOUT <= {~SACK, ~DMR};
      end
      if (rise && MXSTB) LINKUP <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vm3_mux_tx.sv
// Bench for vm3_mux_tx: CPLD receiver model, frame scoreboard, DIV=2 and DIV=3 instances.
module tb_vm3_mux_tx;
  logic       CLK = 1'b0, nRST = 1'b0;
  logic       DCLO = 0, ACLO = 0, HALT = 0, EVNT = 0, DMR = 0, SACK = 0;
  logic [3:0] IRQ = 4'h0;
  logic       MCLK, MXSTB, FRAME, LINKUP;
  logic [1:0] MXOUT;
  logic       MCLK3, MXSTB3, FRAME3, LINKUP3;
  logic [1:0] MXOUT3;

  always #5 CLK = ~CLK;

  vm3_mux_tx #(.DIV(2)) dut (
    .CLK(CLK), .nRST(nRST), .DCLO(DCLO), .ACLO(ACLO), .HALT(HALT), .EVNT(EVNT),
    .IRQ(IRQ), .DMR(DMR), .SACK(SACK), .MCLK(MCLK), .MXOUT(MXOUT), .MXSTB(MXSTB),
    .FRAME(FRAME), .LINKUP(LINKUP));

  vm3_mux_tx #(.DIV(3)) dut3 (
    .CLK(CLK), .nRST(nRST), .DCLO(DCLO), .ACLO(ACLO), .HALT(HALT), .EVNT(EVNT),
    .IRQ(IRQ), .DMR(DMR), .SACK(SACK), .MCLK(MCLK3), .MXOUT(MXOUT3), .MXSTB(MXSTB3),
    .FRAME(FRAME3), .LINKUP(LINKUP3));

  // MXOUT3 may only move on the CLK edge right after an MCLK3 edge.
  assert property (@(posedge CLK) disable iff (!nRST)
    ($past(nRST, 2) && MXOUT3 != $past(MXOUT3)) |->
      (MCLK3 == $past(MCLK3)) && ($past(MCLK3) != $past(MCLK3, 2)));

  // CPLD model: shift on MCLK rise, parallel load on strobe, DMR/SACK on fall.
  logic [7:0] sr = 8'hFF, par = 8'hFF;
  logic [1:0] dm = 2'b11;
  int         stbCnt = 0;
  always @(posedge MCLK) begin
    sr <= {sr[5:0], MXOUT};
    if (MXSTB) begin
      par    <= {sr[5:0], MXOUT};
      stbCnt <= stbCnt + 1;
    end
  end
  always @(negedge MCLK) dm <= MXOUT;

  typedef struct {
    logic dclo, aclo, halt, evnt;
    logic [3:0] irq;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] sb[$];
  int         checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // Returns at the CLK negedge following the requested MCLK edge.
  task automatic waitEdge(input logic lvl, output int n);
    logic p;
    p = MCLK;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      n++;
      if (MCLK == lvl && p != lvl) return;
      p = MCLK;
    end
    timeoutFail("wait_mclk_edge");
  endtask

  task automatic waitFrame();
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (FRAME) return;
    end
    timeoutFail("wait_frame");
  endtask

  task automatic checkStrobe(input string name);
    int n0;
    logic [7:0] e;
    n0 = stbCnt;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (stbCnt != n0) begin
        e = sb.pop_front();
        chk(name, par, e);
        return;
      end
    end
    timeoutFail(name);
  endtask

  task automatic setIn(input vec_t v);
    DCLO = v.dclo; ACLO = v.aclo; HALT = v.halt; EVNT = v.evnt; IRQ = v.irq;
  endtask

  // Sync so the next strobed frame is snapshotted after the current inputs.
  task automatic syncFrame();
    int n;
    waitFrame();
    waitEdge(1'b1, n);
  endtask

  initial begin
    int n, n0, k;
    logic [1:0] seq[4];
    logic pm, ppm, m;
    logic [1:0] px, x;
    int sinceRise;
    bit seenRise;

    vecs[0] = '{0, 0, 0, 0, 4'b0000, 8'hFF};
    vecs[1] = '{1, 0, 0, 0, 4'b0101, 8'h7A};
    vecs[2] = '{0, 1, 1, 0, 4'b0000, 8'h9F};
    vecs[3] = '{0, 0, 0, 1, 4'b1010, 8'hE5};
    vecs[4] = '{1, 1, 1, 1, 4'b1111, 8'h00};
    vecs[5] = '{0, 0, 0, 0, 4'b1000, 8'hF7};
    vecs[6] = '{1, 0, 0, 0, 4'b0000, 8'h7F};
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10; seq[3] = 2'b10;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_mclk", MCLK, 0);
    chk("rst_mxout", MXOUT, 2'b11);
    chk("rst_mxstb", MXSTB, 0);
    chk("rst_frame", FRAME, 0);
    chk("rst_linkup", LINKUP, 0);
    nRST = 1'b1;

    // Idle frames: period, strobe cadence, LINKUP at 4th rise
    for (k = 1; k <= 8; k++) begin
      waitEdge(1'b1, n);
      if (k > 1) chk("idle_period", n, 4);
      chk("idle_mxout", MXOUT, 2'b11);
      chk("idle_mxstb", MXSTB, (k % 4) == 0);
      chk("idle_linkup", LINKUP, k >= 4);
    end

    // Table-driven frame contents through the scoreboard
    for (int i = 0; i < 7; i++) begin
      setIn(vecs[i]);
      syncFrame();
      sb.push_back(vecs[i].exp);
      checkStrobe($sformatf("frame_vec%0d", i));
    end

    // Low-phase slot sequence for DCLO=1, IRQ=0101
    setIn(vecs[1]);
    syncFrame();
    syncFrame();
    for (int s = 0; s < 4; s++) begin
      waitEdge(1'b1, n);
      chk($sformatf("slot%0d_mxout", s), MXOUT, seq[s]);
      chk($sformatf("slot%0d_mxstb", s), MXSTB, s == 3);
    end
    chk("par_7a", par, 8'h7A);

    // DMR/SACK in the high phase
    DMR = 1'b1; SACK = 1'b0;
    waitEdge(1'b0, n);
    for (int i = 0; i < 3; i++) begin
      waitEdge(1'b0, n);
      chk("hi_mxout_dmr", MXOUT, 2'b10);
      chk("cpld_dm_dmr", dm, 2'b10);
    end
    DMR = 1'b0; SACK = 1'b1;
    waitEdge(1'b0, n);
    waitEdge(1'b0, n);
    chk("hi_mxout_sack", MXOUT, 2'b01);
    chk("cpld_dm_sack", dm, 2'b01);

    // IRQ0 drops during slot 2: old frame completes, new value next frame
    syncFrame();
    waitEdge(1'b1, n);
    waitEdge(1'b1, n);
    waitEdge(1'b0, n);
    @(negedge CLK);
    IRQ = 4'b0100;
    sb.push_back(8'h7A);
    checkStrobe("irq_chg_cur");
    sb.push_back(8'h7B);
    checkStrobe("irq_chg_next");

    // Reset during slot 1
    setIn(vecs[1]);
    syncFrame();
    syncFrame();
    waitEdge(1'b1, n);
    waitEdge(1'b0, n);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("mrst_mclk", MCLK, 0);
    chk("mrst_mxout", MXOUT, 2'b11);
    chk("mrst_mxstb", MXSTB, 0);
    chk("mrst_linkup", LINKUP, 0);
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    n0 = stbCnt;
    sb.push_back(8'h7A);
    for (k = 1; k <= 4; k++) begin
      waitEdge(1'b1, n);
      chk("mrst_mxstb_seq", MXSTB, k == 4);
      chk("mrst_linkup_seq", LINKUP, k == 4);
    end
    chk("mrst_stb_count", stbCnt - n0, 1);
    if (sb.size() > 0) chk("mrst_frame", par, sb.pop_front());

    // DIV=3 instance: period and update timing
    DMR = 1'b1; SACK = 1'b0;
    @(negedge CLK);
    pm = MCLK3; ppm = MCLK3; px = MXOUT3;
    sinceRise = 0; seenRise = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge CLK);
      m = MCLK3; x = MXOUT3;
      sinceRise++;
      if (m && !pm) begin
        if (seenRise) chk("div3_period", sinceRise, 6);
        seenRise = 1;
        sinceRise = 0;
      end
      if (x != px) begin
        chk("div3_no_coincident", m, pm);
        chk("div3_one_after_edge", pm != ppm, 1);
      end
      ppm = pm; pm = m; px = x;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
